// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU-sharing block: ALU opcode encodings,
// requester-id width helper and the tag carried alongside each issued op.
package alu_share_arbiter_pkg;

    localparam int ALUOP_WIDTH = 4;

    localparam logic [ALUOP_WIDTH-1:0] ADD_OP  = 4'h0;
    localparam logic [ALUOP_WIDTH-1:0] SUB_OP  = 4'h1;
    localparam logic [ALUOP_WIDTH-1:0] AND_OP  = 4'h2;
    localparam logic [ALUOP_WIDTH-1:0] OR_OP   = 4'h3;
    localparam logic [ALUOP_WIDTH-1:0] XOR_OP  = 4'h4;
    localparam logic [ALUOP_WIDTH-1:0] SLL_OP  = 4'h5;
    localparam logic [ALUOP_WIDTH-1:0] SRL_OP  = 4'h6;
    localparam logic [ALUOP_WIDTH-1:0] SRA_OP  = 4'h7;
    localparam logic [ALUOP_WIDTH-1:0] SLT_OP  = 4'h8;
    localparam logic [ALUOP_WIDTH-1:0] SLTU_OP = 4'h9;

    // Bits needed to name one of n requesters; never narrower than one bit.
    function automatic int req_id_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

    // Delay-line entry: id is wide enough for up to 8 requesters.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } alu_tag_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle: packed per-requester requests, kills, and the
// shared response bus with per-requester valid and busy flags.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32
);
    import alu_share_arbiter_pkg::*;

    logic [NUM_REQ-1:0]             i_req_valid;
    logic [NUM_REQ-1:0]             o_req_ready;
    logic [NUM_REQ*ALUOP_WIDTH-1:0] i_req_op;
    logic [NUM_REQ*XLEN-1:0]        i_req_a;
    logic [NUM_REQ*XLEN-1:0]        i_req_b;
    logic [NUM_REQ-1:0]             i_kill;
    logic [NUM_REQ-1:0]             o_rsp_valid;
    logic [XLEN-1:0]                o_rsp_data;
    logic [NUM_REQ-1:0]             o_busy;

    modport master (
        output i_req_valid, i_req_op, i_req_a, i_req_b, i_kill,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_op, i_req_a, i_req_b, i_kill,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_busy
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from a
// registered pointer; the pointer moves past the winner only on advance.
module rr_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               i_req,
    input  logic                             i_advance,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic [req_id_width(NUM_REQ)-1:0] o_grant_id
);
    localparam int PTR_W = req_id_width(NUM_REQ);

    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   ptr_next_s;
    logic [PTR_W-1:0]   idx_s;
    logic [PTR_W-1:0]   grant_id_s;
    logic [PTR_W:0]     sum_s;
    logic               found_s;
    logic [NUM_REQ-1:0] grant_s;

    // First requesting index at or above the pointer wins, wrapping modulo NUM_REQ.
    always_comb begin
        grant_s    = {NUM_REQ{1'b0}};
        grant_id_s = {PTR_W{1'b0}};
        ptr_next_s = ptr_r;
        found_s    = 1'b0;
        sum_s      = {(PTR_W+1){1'b0}};
        idx_s      = {PTR_W{1'b0}};
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s = {1'b0, ptr_r} + (PTR_W+1)'(off);
            if (sum_s >= (PTR_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (PTR_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PTR_W-1:0];
            if (!found_s && i_req[idx_s]) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                grant_id_s     = idx_s;
                if (idx_s == PTR_W'(NUM_REQ - 1)) begin
                    ptr_next_s = {PTR_W{1'b0}};
                end else begin
                    ptr_next_s = idx_s + PTR_W'(1);
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer register: advances to one past the granted index when the grant is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (i_advance) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign o_grant    = grant_s;
    assign o_grant_id = grant_id_s;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters. Each issued op carries
// its requester id through a delay line matched to the ALU latency so the
// result can be routed back; a kill drops in-flight work for that requester.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_share_arbiter_if.slave     req_if,
    output logic                   o_alu_valid,
    output logic [ALUOP_WIDTH-1:0] o_alu_op,
    output logic [XLEN-1:0]        o_alu_a,
    output logic [XLEN-1:0]        o_alu_b,
    input  logic [XLEN-1:0]        i_alu_result
);
    localparam int ID_W = req_id_width(NUM_REQ);

    logic [NUM_REQ-1:0]     elig_s;
    logic [NUM_REQ-1:0]     grant_s;
    logic [ID_W-1:0]        grant_id_s;
    logic                   issue_s;
    logic [ALUOP_WIDTH-1:0] sel_op_s;
    logic [XLEN-1:0]        sel_a_s;
    logic [XLEN-1:0]        sel_b_s;
    alu_tag_t               tag_r [0:ALU_LAT];
    logic [ALU_LAT:0]       killed_s;
    logic                   rsp_fire_s;
    logic [NUM_REQ-1:0]     rsp_hit_s;
    logic [NUM_REQ-1:0]     busy_r;
    logic [NUM_REQ-1:0]     rsp_valid_r;
    logic [XLEN-1:0]        rsp_data_r;

    // A requester being killed is not granted in the same cycle.
    assign elig_s  = req_if.i_req_valid & ~busy_r & ~req_if.i_kill;
    assign issue_s = |grant_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .reset      (reset),
        .i_req      (elig_s),
        .i_advance  (issue_s),
        .o_grant    (grant_s),
        .o_grant_id (grant_id_s)
    );

    // Steer the granted requester's payload toward the ALU input registers.
    always_comb begin
        sel_op_s = {ALUOP_WIDTH{1'b0}};
        sel_a_s  = {XLEN{1'b0}};
        sel_b_s  = {XLEN{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_s[k]) begin
                sel_op_s = req_if.i_req_op[k*ALUOP_WIDTH +: ALUOP_WIDTH];
                sel_a_s  = req_if.i_req_a[k*XLEN +: XLEN];
                sel_b_s  = req_if.i_req_b[k*XLEN +: XLEN];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // ALU input registers: load on issue, otherwise drop valid and hold operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_alu_valid <= 1'b0;
            o_alu_op    <= {ALUOP_WIDTH{1'b0}};
            o_alu_a     <= {XLEN{1'b0}};
            o_alu_b     <= {XLEN{1'b0}};
        end else if (issue_s) begin
            o_alu_valid <= 1'b1;
            o_alu_op    <= sel_op_s;
            o_alu_a     <= sel_a_s;
            o_alu_b     <= sel_b_s;
        end else begin
            o_alu_valid <= 1'b0;
        end
    end

    // Mark every delay-line entry whose owner is being killed this cycle.
    always_comb begin
        killed_s = {(ALU_LAT+1){1'b0}};
        for (int i = 0; i <= ALU_LAT; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (tag_r[i].id == 3'(k)) begin
                    killed_s[i] = killed_s[i] | req_if.i_kill[k];
                end else begin
                    killed_s[i] = killed_s[i];
                end
            end
        end
    end

    // The head entry lines up with i_alu_result; a surviving head becomes a response.
    assign rsp_fire_s = tag_r[ALU_LAT].valid & ~killed_s[ALU_LAT];

    // Decode the head id into the one-hot response target.
    always_comb begin
        rsp_hit_s = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rsp_fire_s && (tag_r[ALU_LAT].id == 3'(k))) begin
                rsp_hit_s[k] = 1'b1;
            end else begin
                rsp_hit_s[k] = 1'b0;
            end
        end
    end

    // Tag delay line: stage 0 loads alongside o_alu_valid, kills mask entries as they shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_r[i] <= alu_tag_t'{valid: 1'b0, id: 3'd0};
            end
        end else begin
            tag_r[0] <= alu_tag_t'{valid: issue_s, id: 3'(grant_id_s)};
            for (int i = 1; i <= ALU_LAT; i++) begin
                tag_r[i] <= alu_tag_t'{valid: tag_r[i-1].valid & ~killed_s[i-1],
                                       id:    tag_r[i-1].id};
            end
        end
    end

    // Busy and response registers; busy clears on response or kill so the
    // requester can be re-granted in the cycle its response is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= {NUM_REQ{1'b0}};
            rsp_valid_r <= {NUM_REQ{1'b0}};
            rsp_data_r  <= {XLEN{1'b0}};
        end else begin
            busy_r      <= grant_s | (busy_r & ~req_if.i_kill & ~rsp_hit_s);
            rsp_valid_r <= rsp_hit_s;
            if (rsp_fire_s) begin
                rsp_data_r <= i_alu_result;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign req_if.o_req_ready = grant_s;
    assign req_if.o_rsp_valid = rsp_valid_r;
    assign req_if.o_rsp_data  = rsp_data_r;
    assign req_if.o_busy      = busy_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: one instance with ALU_LAT=1 for the single-op, fairness,
// kill, reset and back-to-back scenarios; one with ALU_LAT=2 for full load.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int XW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset1;
    logic reset2;

    alu_share_arbiter_if #(.NUM_REQ(N), .XLEN(XW)) bus1 ();
    alu_share_arbiter_if #(.NUM_REQ(N), .XLEN(XW)) bus2 ();

    logic                   alu1_valid;
    logic [ALUOP_WIDTH-1:0] alu1_op;
    logic [XW-1:0]          alu1_a;
    logic [XW-1:0]          alu1_b;
    logic [XW-1:0]          alu1_res;
    logic                   alu2_valid;
    logic [ALUOP_WIDTH-1:0] alu2_op;
    logic [XW-1:0]          alu2_a;
    logic [XW-1:0]          alu2_b;
    logic [XW-1:0]          alu2_res;

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(XW), .ALU_LAT(1)) u_dut1 (
        .clk          (clk),
        .reset        (reset1),
        .req_if       (bus1),
        .o_alu_valid  (alu1_valid),
        .o_alu_op     (alu1_op),
        .o_alu_a      (alu1_a),
        .o_alu_b      (alu1_b),
        .i_alu_result (alu1_res)
    );

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(XW), .ALU_LAT(2)) u_dut2 (
        .clk          (clk),
        .reset        (reset2),
        .req_if       (bus2),
        .o_alu_valid  (alu2_valid),
        .o_alu_op     (alu2_op),
        .o_alu_a      (alu2_a),
        .o_alu_b      (alu2_b),
        .i_alu_result (alu2_res)
    );

    // Reference ALU behaviour.
    function automatic logic [XW-1:0] alu_f(input logic [ALUOP_WIDTH-1:0] op,
                                            input logic [XW-1:0] a,
                                            input logic [XW-1:0] b);
        case (op)
            ADD_OP:  return a + b;
            SUB_OP:  return a - b;
            XOR_OP:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU models: one register stage per cycle of latency.
    logic [XW-1:0] res1_r;
    logic [XW-1:0] res2_r [0:1];
    always @(posedge clk) begin
        res1_r    <= alu_f(alu1_op, alu1_a, alu1_b);
        res2_r[0] <= alu_f(alu2_op, alu2_a, alu2_b);
        res2_r[1] <= res2_r[0];
    end
    assign alu1_res = res1_r;
    assign alu2_res = res2_r[1];

    int n_pass;
    int n_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req1(input int k, input logic [ALUOP_WIDTH-1:0] op,
                            input logic [XW-1:0] a, input logic [XW-1:0] b);
        bus1.i_req_op[k*ALUOP_WIDTH +: ALUOP_WIDTH] = op;
        bus1.i_req_a[k*XW +: XW] = a;
        bus1.i_req_b[k*XW +: XW] = b;
    endtask

    logic [3:0]  exp_rdy;
    logic [3:0]  exp_rsp;
    logic [63:0] exp_val;
    int          kk;

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset1  = 1'b1;
        reset2  = 1'b1;
        bus1.i_req_valid = 4'b0000; bus1.i_kill = 4'b0000;
        bus1.i_req_op = '0; bus1.i_req_a = '0; bus1.i_req_b = '0;
        bus2.i_req_valid = 4'b0000; bus2.i_kill = 4'b0000;
        bus2.i_req_op = '0; bus2.i_req_a = '0; bus2.i_req_b = '0;
        repeat (2) tick();
        reset1 = 1'b0;
        reset2 = 1'b0;
        #1;

        // Reset state
        chk("rst_alu_valid", 64'(alu1_valid), 64'd0);
        chk("rst_alu_a",     64'(alu1_a), 64'd0);
        chk("rst_rsp_valid", 64'(bus1.o_rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(bus1.o_rsp_data), 64'd0);
        chk("rst_busy",      64'(bus1.o_busy), 64'd0);
        chk("rst2_busy",     64'(bus2.o_busy), 64'd0);

        // Single request from requester 2: 5 + 7
        set_req1(2, ADD_OP, 32'd5, 32'd7);
        bus1.i_req_valid = 4'b0100;
        #1;
        chk("t1_ready", 64'(bus1.o_req_ready), 64'h4);
        tick();
        bus1.i_req_valid = 4'b0000;
        #1;
        chk("t1_alu_valid", 64'(alu1_valid), 64'd1);
        chk("t1_alu_op",    64'(alu1_op), 64'(ADD_OP));
        chk("t1_alu_a",     64'(alu1_a), 64'd5);
        chk("t1_alu_b",     64'(alu1_b), 64'd7);
        chk("t1_busy_t1",   64'(bus1.o_busy), 64'h4);
        tick();
        chk("t1_rsp_t2",    64'(bus1.o_rsp_valid), 64'd0);
        chk("t1_busy_t2",   64'(bus1.o_busy), 64'h4);
        tick();
        chk("t1_rsp_t3",    64'(bus1.o_rsp_valid), 64'h4);
        chk("t1_data_t3",   64'(bus1.o_rsp_data), 64'd12);
        chk("t1_busy_t3",   64'(bus1.o_busy), 64'd0);

        // Fairness with pointer at 3: requesters 1 and 3 hold valid
        set_req1(1, ADD_OP, 32'd1, 32'd1);
        set_req1(3, ADD_OP, 32'd3, 32'd3);
        bus1.i_req_valid = 4'b1010;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
            end
            case (i)
                0: exp_rdy = 4'b1000;
                1: exp_rdy = 4'b0010;
                2: exp_rdy = 4'b0000;
                3: exp_rdy = 4'b1000;
                default: exp_rdy = 4'b0010;
            endcase
            chk($sformatf("t3_ready_%0d", i), 64'(bus1.o_req_ready), 64'(exp_rdy));
            if (i == 3) begin
                chk("t3_rsp3",  64'(bus1.o_rsp_valid), 64'h8);
                chk("t3_data3", 64'(bus1.o_rsp_data), 64'd6);
            end
            if (i == 4) begin
                chk("t3_rsp1",  64'(bus1.o_rsp_valid), 64'h2);
                chk("t3_data1", 64'(bus1.o_rsp_data), 64'd2);
            end
        end
        tick();
        bus1.i_req_valid = 4'b0000;
        repeat (4) tick();

        // Kill in flight on requester 1, then a fresh XOR from requester 1
        set_req1(1, SUB_OP, 32'd10, 32'd3);
        bus1.i_req_valid = 4'b0010;
        #1;
        chk("t4_ready_k0", 64'(bus1.o_req_ready), 64'h2);
        tick();
        bus1.i_req_valid = 4'b0000;
        bus1.i_kill = 4'b0010;
        #1;
        chk("t4_alu_valid", 64'(alu1_valid), 64'd1);
        chk("t4_alu_op",    64'(alu1_op), 64'(SUB_OP));
        tick();
        bus1.i_kill = 4'b0000;
        #1;
        chk("t4_busy_k2", 64'(bus1.o_busy), 64'd0);
        chk("t4_rsp_k2",  64'(bus1.o_rsp_valid), 64'd0);
        set_req1(1, XOR_OP, 32'd6, 32'd3);
        bus1.i_req_valid = 4'b0010;
        #1;
        chk("t4_ready_k2", 64'(bus1.o_req_ready), 64'h2);
        tick();
        bus1.i_req_valid = 4'b0000;
        #1;
        chk("t4_rsp_k3",    64'(bus1.o_rsp_valid), 64'd0);
        chk("t4_alu_op_k3", 64'(alu1_op), 64'(XOR_OP));
        tick();
        chk("t4_rsp_k4",  64'(bus1.o_rsp_valid), 64'd0);
        tick();
        chk("t4_rsp_k5",  64'(bus1.o_rsp_valid), 64'h2);
        chk("t4_data_k5", 64'(bus1.o_rsp_data), 64'd5);

        // Reset with three ops in flight or issuing
        set_req1(0, ADD_OP, 32'd20, 32'd1);
        set_req1(2, ADD_OP, 32'd40, 32'd2);
        set_req1(3, ADD_OP, 32'd60, 32'd3);
        bus1.i_req_valid = 4'b1101;
        #1;
        chk("t5_ready_r0", 64'(bus1.o_req_ready), 64'h4);
        tick();
        chk("t5_ready_r1", 64'(bus1.o_req_ready), 64'h8);
        tick();
        chk("t5_ready_r2", 64'(bus1.o_req_ready), 64'h1);
        reset1 = 1'b1;
        tick();
        chk("t5_alu_valid", 64'(alu1_valid), 64'd0);
        chk("t5_alu_a",     64'(alu1_a), 64'd0);
        chk("t5_alu_b",     64'(alu1_b), 64'd0);
        chk("t5_rsp_valid", 64'(bus1.o_rsp_valid), 64'd0);
        chk("t5_rsp_data",  64'(bus1.o_rsp_data), 64'd0);
        chk("t5_busy",      64'(bus1.o_busy), 64'd0);
        bus1.i_req_valid = 4'b0000;
        reset1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t5_quiet_%0d", i), 64'(bus1.o_rsp_valid), 64'd0);
        end

        // Back-to-back on requester 0: period ALU_LAT+2 = 3
        set_req1(0, ADD_OP, 32'd9, 32'd1);
        bus1.i_req_valid = 4'b0001;
        #1;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) begin
                tick();
            end
            exp_rdy = ((n % 3) == 0) ? 4'b0001 : 4'b0000;
            exp_rsp = ((n >= 3) && ((n % 3) == 0)) ? 4'b0001 : 4'b0000;
            chk($sformatf("t6_ready_%0d", n), 64'(bus1.o_req_ready), 64'(exp_rdy));
            chk($sformatf("t6_rsp_%0d", n), 64'(bus1.o_rsp_valid), 64'(exp_rsp));
            chk($sformatf("t6_alu_valid_%0d", n), 64'(alu1_valid), ((n % 3) == 1) ? 64'd1 : 64'd0);
            if (exp_rsp != 4'b0000) begin
                chk($sformatf("t6_data_%0d", n), 64'(bus1.o_rsp_data), 64'd10);
            end
        end
        bus1.i_req_valid = 4'b0000;

        // Full load on the ALU_LAT=2 instance: requester k adds 100*(k+1) and k
        for (int k = 0; k < N; k++) begin
            bus2.i_req_op[k*ALUOP_WIDTH +: ALUOP_WIDTH] = ADD_OP;
            bus2.i_req_a[k*XW +: XW] = 32'(100 * (k + 1));
            bus2.i_req_b[k*XW +: XW] = 32'(k);
        end
        bus2.i_req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) begin
                tick();
            end
            exp_rdy = 4'b0001 << (n % 4);
            chk($sformatf("t2_ready_%0d", n), 64'(bus2.o_req_ready), 64'(exp_rdy));
            if (n >= 1) begin
                kk = (n - 1) % 4;
                chk($sformatf("t2_alu_valid_%0d", n), 64'(alu2_valid), 64'd1);
                chk($sformatf("t2_alu_a_%0d", n), 64'(alu2_a), 64'(100 * (kk + 1)));
            end
            if (n >= 4) begin
                kk = (n - 4) % 4;
                exp_rsp = 4'b0001 << kk;
                exp_val = 64'(101 * kk + 100);
                chk($sformatf("t2_rsp_%0d", n), 64'(bus2.o_rsp_valid), 64'(exp_rsp));
                chk($sformatf("t2_data_%0d", n), 64'(bus2.o_rsp_data), exp_val);
            end else begin
                chk($sformatf("t2_rsp_%0d", n), 64'(bus2.o_rsp_valid), 64'd0);
            end
        end
        bus2.i_req_valid = 4'b0000;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one pipelined ALU among NUM_REQ requesters (harts or functional clients) using round-robin arbitration.
- Each requester may have at most one operation in flight.
- The block drives the ALU input registers and carries a requester tag through a delay line matched to the ALU latency.
- It routes each result back to the requester that issued it, and supports per-requester kill of in-flight work.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- XLEN, 32, operand/result width.
- ALU_LAT, 1, cycles from o_alu_valid high to i_alu_result valid (1..4).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester grant/accept; combinational, one-hot or zero.
- i_req_op  in  NUM_REQ*ALUOP_WIDTH  packed ALUOp per requester; requester k occupies bits [k*ALUOP_WIDTH +: ALUOP_WIDTH].
- i_req_a  in  NUM_REQ*XLEN  packed operand A.
- i_req_b  in  NUM_REQ*XLEN  packed operand B.
- i_kill  in  NUM_REQ  per-requester discard of in-flight/pending result.
- o_alu_valid  out  1  registered op-valid to ALU.
- o_alu_op  out  ALUOP_WIDTH  registered ALUOp to ALU.
- o_alu_a  out  XLEN  registered operand A.
- o_alu_b  out  XLEN  registered operand B.
- i_alu_result  in  XLEN  ALU result, valid ALU_LAT cycles after o_alu_valid.
- o_rsp_valid  out  NUM_REQ  registered one-hot response valid.
- o_rsp_data  out  XLEN  registered result, shared by all requesters.
- o_busy  out  NUM_REQ  per-requester in-flight flag (registered).

Behaviour:
- Reset:
  - o_alu_valid=0, o_alu_op='0, o_alu_a=0, o_alu_b=0.
  - o_rsp_valid=0, o_rsp_data=0, o_busy=0.
  - Round-robin pointer=0; delay-line valids=0.
- Eligibility: requester k is eligible when i_req_valid[k] & ~busy[k] & ~i_kill[k].
- Grant selection:
  - Grant goes to the first eligible index scanning from the pointer upward, with modulo-NUM_REQ wrap.
  - o_req_ready = grant (combinational).
  - A transfer occurs when i_req_valid[k] & o_req_ready[k].
  - Requesters hold valid and payload stable until ready.
- On transfer to k at edge T:
  - o_alu_* take requester k's payload and o_alu_valid=1 during cycle T+1.
  - busy[k] sets.
  - Pointer becomes (k+1) mod NUM_REQ.
  - With no transfer, o_alu_valid=0, the other o_alu_* hold their value, and the pointer holds.
- Tag delay line:
  - ALU_LAT+1 stages, each carrying {valid, id} with id width max(1,$clog2(NUM_REQ)).
  - Stage 0 loads at issue, aligned with o_alu_valid.
  - The stage aligned with i_alu_result is the delay-line head.
- Response:
  - When the head is valid with id=k, at the next edge: o_rsp_valid[k]=1 for one cycle, o_rsp_data=i_alu_result, busy[k] clears.
  - o_rsp_data holds its value when no response occurs.
  - Total latency from transfer edge to o_rsp_valid high: ALU_LAT+2 cycles.
  - Throughput: one issue per cycle across requesters.
  - Per-requester rate is 1 per ALU_LAT+2 cycles, because ready can reassert in the cycle o_rsp_valid is high (busy already clear).
- Kill:
  - i_kill[k] in cycle C clears every delay-line valid whose id=k, at the same edge as the shift.
  - If o_rsp_valid[k] would rise at that edge, it is suppressed.
  - busy[k] clears at the edge, and k is not granted in cycle C.
  - If the result is already on o_rsp_valid in cycle C, it is not retracted.
- Simultaneous response and issue for the same k is impossible; busy blocks it.
- Simultaneous response for k and issue for j≠k both occur normally.
- Reset mid-operation: all in-flight ops are dropped and no response is produced for them.
- The block never inspects the ALUOp value; '0 or undefined codes pass through unchanged.

Decomposition:
- riscv_pkg (existing) supplies ALUOP_WIDTH and the *_OP constants.
- Add to the package: localparam-style function req_id_width(n), and typedef struct packed {logic valid; logic [2:0] id;} alu_tag_t sized for NUM_REQ≤8.
- One sub-module: rr_arbiter.
  - Inputs: clk, reset, i_req[NUM_REQ], i_advance.
  - Output: o_grant[NUM_REQ], one-hot, plus a registered pointer.
  - Reused by other shared-resource blocks.

Test Plan:
- Reset then single request: requester 2 with ADD_OP, a=5, b=7; ALU model returns a+b, ALU_LAT=1. Required: o_alu_valid at T+1 with op=ADD_OP, o_rsp_valid=4'b0100 and o_rsp_data=12 at T+3, o_busy[2] low again in that cycle.
- All four requesting continuously, ALU_LAT=2. Required: grants in order 0,1,2,3,0…, one o_alu_valid every cycle with no gaps while each requester's busy permits, responses in issue order.
- Fairness after wrap: pointer at 3, requesters 1 and 3 valid. Required: grant 3, then 1; requester 1 is never starved for more than NUM_REQ-1 grants.
- Kill in flight: issue from 1 (SUB_OP, 10, 3), assert i_kill[1] in the cycle after issue. Required: no o_rsp_valid[1], busy[1]=0 next cycle, and a new request from 1 (XOR_OP, 6, 3) returns 5 while the killed result does not appear.
- Reset asserted while 3 ops are in flight. Required: all outputs at reset values next cycle, and no o_rsp_valid for 8 cycles after deassert with no requests.
- Back-to-back on one requester: requester 0 holds valid. Required: re-accept in the cycle its o_rsp_valid is high, steady period ALU_LAT+2.
